// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch buffer sitting directly behind the instruction cache.
// The cache delivers one 8-byte-aligned fetch group per cycle: two instruction
// words with 2-bit predecode tags and a per-slot valid mask. The valid slots
// are packed in order into a circular queue. The queue presents up to two
// in-order instructions per cycle to decode. A flush discards everything
// queued, for use on a branch redirect or an exception.
//
// Parameters
//   DEPTH   number of queue entries (power of 2, >= 4)
//
// Ports
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   flush          discard all queued entries; has priority over enq/deq
//   in_valid       fetch group present
//   in_ready       at least two free entries
//   in_pc          address of slot 0, bits [2:0] are zero
//   in_instr       slot0 = [31:0], slot1 = [63:32]
//   in_predecode   slot0 = [1:0], slot1 = [3:2]
//                  (00 normal, 01 branch, 10 return, 11 call)
//   in_mask        per-slot valid; 2'b10 for a fetch that started at pc+4
//   out_valid      issue slots valid: 00, 01 or 11
//   out_pc0/1      PC of issue slot 0/1
//   out_instr0/1   instruction of issue slot 0/1
//   out_pred0/1    predecode of issue slot 0/1
//   out_accept     decode consumes slots: 00, 01 or 11, within out_valid
//
// Build options
//   FQ_BRANCH_PAIR_EN  when defined, a control-transfer instruction is never
//                      issued without its delay slot
//                      (when undefined, out_valid follows count only)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [63:0] in_instr,
    input  logic [3:0]  in_predecode,
    input  logic [1:0]  in_mask,

    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_instr0,
    output logic [31:0] out_instr1,
    output logic [1:0]  out_pred0,
    output logic [1:0]  out_pred1,
    input  logic [1:0]  out_accept
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   READY_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [1:0]  pred_mem  [DEPTH];

    // ------------------------------------------------------------------
    // Derived pointers and handshakes
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             enq_fire;
    logic [PTR_W:0]   n_in;
    logic [PTR_W:0]   n_out;
    logic [1:0]       accept_eff;

    assign head_p1 = head_q + PTR_ONE;
    assign tail_p1 = tail_q + PTR_ONE;

    // Independent of the same-cycle dequeue so the cache-side handshake does
    // not sit behind the decode stall path.
    assign in_ready = (count_q <= READY_MAX);
    assign enq_fire = in_valid && in_ready;

    assign n_in = enq_fire ? ({{PTR_W{1'b0}}, in_mask[0]} + {{PTR_W{1'b0}}, in_mask[1]})
                           : '0;

    // Decode can never take more than is offered, even if it misbehaves.
    assign accept_eff = out_accept & out_valid;
    assign n_out      = {{PTR_W{1'b0}}, accept_eff[0]} + {{PTR_W{1'b0}}, accept_eff[1]};

    // ------------------------------------------------------------------
    // Issue-slot view
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 2'b00;
        if (count_q >= CNT_TWO) begin
            out_valid = 2'b11;
        end else if (count_q == CNT_ONE) begin
            out_valid = 2'b01;
        end
`ifdef FQ_BRANCH_PAIR_EN
        // A branch in slot 1 would be split from its delay slot: hold it back
        // so it reaches slot 0 next cycle. A lone branch at head waits for
        // its delay slot to arrive.
        if ((count_q >= CNT_TWO) && (pred_mem[head_p1] != 2'b00)) begin
            out_valid = 2'b01;
        end else if ((count_q == CNT_ONE) && (pred_mem[head_q] != 2'b00)) begin
            out_valid = 2'b00;
        end
`endif
    end

    assign out_pc0    = pc_mem[head_q];
    assign out_instr0 = instr_mem[head_q];
    assign out_pred0  = pred_mem[head_q];
    assign out_pc1    = pc_mem[head_p1];
    assign out_instr1 = instr_mem[head_p1];
    assign out_pred1  = pred_mem[head_p1];

    // ------------------------------------------------------------------
    // Pointer / count next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + n_out[PTR_W-1:0];
            tail_d  = tail_q + n_in[PTR_W-1:0];
            count_d = count_q + n_in - n_out;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage (not reset; occupancy is tracked by count)
    // Valid slots are packed at tail, slot 0 first; a lone slot 1 lands
    // at tail itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            unique case (in_mask)
                2'b01: begin
                    pc_mem[tail_q]    <= in_pc;
                    instr_mem[tail_q] <= in_instr[31:0];
                    pred_mem[tail_q]  <= in_predecode[1:0];
                end
                2'b10: begin
                    pc_mem[tail_q]    <= in_pc + 32'd4;
                    instr_mem[tail_q] <= in_instr[63:32];
                    pred_mem[tail_q]  <= in_predecode[3:2];
                end
                2'b11: begin
                    pc_mem[tail_q]     <= in_pc;
                    instr_mem[tail_q]  <= in_instr[31:0];
                    pred_mem[tail_q]   <= in_predecode[1:0];
                    pc_mem[tail_p1]    <= in_pc + 32'd4;
                    instr_mem[tail_p1] <= in_instr[63:32];
                    pred_mem[tail_p1]  <= in_predecode[3:2];
                end
                default: ;
            endcase
        end
    end

`ifdef SIMULATION
    // Decode may only take a prefix of what is offered.
    accept_legal_a: assert property (@(posedge clk) disable iff (!resetn)
        ((out_accept & ~out_valid) == 2'b00) && (out_accept != 2'b10));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [63:0] in_instr;
    logic [3:0]  in_predecode;
    logic [1:0]  in_mask;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_pc1;
    logic [31:0] out_instr0, out_instr1;
    logic [1:0]  out_pred0, out_pred1;
    logic [1:0]  out_accept;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_predecode (in_predecode),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_pc0      (out_pc0),
        .out_pc1      (out_pc1),
        .out_instr0   (out_instr0),
        .out_instr1   (out_instr1),
        .out_pred0    (out_pred0),
        .out_pred1    (out_pred1),
        .out_accept   (out_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: an ordered list of instructions in the buffer
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  pred;
    } ent_t;

    ent_t mq[$];

    function automatic logic [1:0] exp_valid();
        int n;
        n = mq.size();
        if (n == 0) return 2'b00;
`ifdef FQ_BRANCH_PAIR_EN
        if (n == 1) return (mq[0].pred != 2'b00) ? 2'b00 : 2'b01;
        if (mq[1].pred != 2'b00) return 2'b01;
        return 2'b11;
`else
        return (n == 1) ? 2'b01 : 2'b11;
`endif
    endfunction

    function automatic logic exp_ready();
        return (mq.size() <= DEPTH - 2) ? 1'b1 : 1'b0;
    endfunction

    // One clock: predict the effect of the driven inputs, clock, commit, and
    // leave the bench 1 time unit after the edge.
    task automatic step();
        logic [1:0] ev;
        int         n_out;
        bit         fire;
        ent_t       e;
        ev    = exp_valid();
        fire  = in_valid && exp_ready();
        n_out = int'((out_accept & ev) == 2'b11) * 2 + int'((out_accept & ev) == 2'b01);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            for (int k = 0; k < n_out; k++) void'(mq.pop_front());
            if (fire) begin
                if (in_mask[0]) begin
                    e.pc = in_pc; e.instr = in_instr[31:0]; e.pred = in_predecode[1:0];
                    mq.push_back(e);
                end
                if (in_mask[1]) begin
                    e.pc = in_pc + 32'd4; e.instr = in_instr[63:32]; e.pred = in_predecode[3:2];
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic set_idle();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_pc        = '0;
        in_instr     = '0;
        in_predecode = '0;
        in_mask      = 2'b00;
        out_accept   = 2'b00;
    endtask

    task automatic drive_group(input logic [31:0] pc, input logic [63:0] instr,
                               input logic [3:0] pred, input logic [1:0] mask);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_instr     = instr;
        in_predecode = pred;
        in_mask      = mask;
    endtask

    task automatic do_flush();
        set_idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        resetn = 1'b0;
        #3;
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL reset_out_valid: got %b want 00", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        #10 resetn = 1'b1;
        @(posedge clk); #1;
        mq.delete();
    endtask

    task automatic test_basic();
        drive_group(32'h1000, {32'h24020002, 32'h24010001}, 4'b0000, 2'b11);
        step();
        set_idle();
        checks++;
        if (out_valid !== 2'b11) begin
            errors++; $display("FAIL basic_valid: got %b want 11", out_valid);
        end
        checks++;
        if (out_pc0 !== 32'h1000 || out_pc1 !== 32'h1004) begin
            errors++; $display("FAIL basic_pc: got %h/%h want 00001000/00001004", out_pc0, out_pc1);
        end
        checks++;
        if (out_instr0 !== 32'h24010001 || out_instr1 !== 32'h24020002) begin
            errors++; $display("FAIL basic_instr: got %h/%h want 24010001/24020002", out_instr0, out_instr1);
        end
        out_accept = 2'b11;
        step();
        out_accept = 2'b00;
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL basic_drain: got %b want 00", out_valid);
        end
    endtask

    task automatic test_half_group();
        logic [1:0] want;
        drive_group(32'h2000, {32'h03E00008, 32'hDEADBEEF}, 4'b1000, 2'b10);
        step();
        set_idle();
`ifdef FQ_BRANCH_PAIR_EN
        want = 2'b00;
`else
        want = 2'b01;
`endif
        checks++;
        if (out_valid !== want) begin
            errors++; $display("FAIL half_valid: got %b want %b", out_valid, want);
        end
        checks++;
        if (out_pc0 !== 32'h2004 || out_pred0 !== 2'b10 || out_instr0 !== 32'h03E00008) begin
            errors++; $display("FAIL half_slot0: got pc=%h pred=%b instr=%h want pc=00002004 pred=10 instr=03e00008",
                               out_pc0, out_pred0, out_instr0);
        end
        do_flush();
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL half_flush: got %b want 00", out_valid);
        end
    endtask

    task automatic test_full_wrap();
        for (int g = 0; g < 4; g++) begin
            drive_group(32'h100 + 32'(g * 8), {32'hB000_0000 + 32'(g), 32'hA000_0000 + 32'(g)},
                        4'b0000, 2'b11);
            step();
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 2'b11) begin
            errors++; $display("FAIL full_state: got ready=%b valid=%b want 0/11", in_ready, out_valid);
        end
        drive_group(32'h120, {32'hB000_0004, 32'hA000_0004}, 4'b0000, 2'b11);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_pc0 !== 32'h100) begin
            errors++; $display("FAIL full_hold: got ready=%b pc0=%h want 0/00000100", in_ready, out_pc0);
        end
        out_accept = 2'b11;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_pc0 !== 32'h108) begin
            errors++; $display("FAIL full_pop: got ready=%b pc0=%h want 1/00000108", in_ready, out_pc0);
        end
        out_accept = 2'b00;
        step();
        set_idle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_reaccept: got ready=%b want 0", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 2'b11 || out_pc0 !== 32'h108 + 32'(i * 8)
                || out_pc1 !== 32'h10C + 32'(i * 8)) begin
                errors++; $display("FAIL wrap_order[%0d]: got v=%b pc=%h/%h want 11 %h/%h", i,
                                   out_valid, out_pc0, out_pc1, 32'h108 + 32'(i * 8), 32'h10C + 32'(i * 8));
            end
            out_accept = 2'b11;
            step();
        end
        out_accept = 2'b00;
        checks++;
        if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_empty: got v=%b ready=%b want 00/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 3; g++) begin
            drive_group(32'h200 + 32'(g * 8), {32'(g), 32'(g + 100)}, 4'b0000, 2'b11);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive_group(32'h218 + 32'(i * 8), {32'(i + 3), 32'(i + 103)}, 4'b0000, 2'b11);
            else in_valid = 1'b0;
            checks++;
            if (out_valid !== 2'b11 || out_pc0 !== 32'h200 + 32'(i * 8)
                || out_pc1 !== 32'h204 + 32'(i * 8)) begin
                errors++; $display("FAIL b2b_order[%0d]: got v=%b pc=%h/%h want 11 %h/%h", i,
                                   out_valid, out_pc0, out_pc1, 32'h200 + 32'(i * 8), 32'h204 + 32'(i * 8));
            end
            if (i < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
                end
            end
            out_accept = 2'b11;
            step();
        end
        set_idle();
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL b2b_empty: got %b want 00", out_valid);
        end
    endtask

    task automatic test_flush_reset();
        drive_group(32'h400, 64'h1111_1111_2222_2222, 4'b0000, 2'b11); step();
        drive_group(32'h408, 64'h3333_3333_4444_4444, 4'b0000, 2'b11); step();
        drive_group(32'h410, 64'h5555_5555_6666_6666, 4'b0000, 2'b01); step();
        drive_group(32'h500, 64'h7777_7777_8888_8888, 4'b0000, 2'b11);
        flush      = 1'b1;
        out_accept = 2'b01;
        step();
        set_idle();
        checks++;
        if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got v=%b ready=%b want 00/1", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 2'b00) begin
            errors++; $display("FAIL flush_group_absent: got %b want 00", out_valid);
        end
        drive_group(32'h600, 64'h9999_9999_AAAA_AAAA, 4'b0000, 2'b11); step();
        drive_group(32'h608, 64'hBBBB_BBBB_CCCC_CCCC, 4'b0000, 2'b11); step();
        set_idle();
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h600) begin
            errors++; $display("FAIL reset_pre: got v=%b pc0=%h want 11/00000600", out_valid, out_pc0);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 2'b00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got v=%b ready=%b want 00/1", out_valid, in_ready);
        end
        mq.delete();
        #1 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_branch_pair();
        logic [1:0] want;
        drive_group(32'h3000, {32'h1000_0003, 32'h0000_0000}, 4'b0100, 2'b11); step();
        drive_group(32'h3008, {32'hFFFF_FFFF, 32'h0000_0000}, 4'b0000, 2'b01); step();
        set_idle();
`ifdef FQ_BRANCH_PAIR_EN
        want = 2'b01;
`else
        want = 2'b11;
`endif
        checks++;
        if (out_valid !== want || out_pc0 !== 32'h3000) begin
            errors++; $display("FAIL bpair_first: got v=%b pc0=%h want %b/00003000", out_valid, out_pc0, want);
        end
        out_accept = 2'b01;
        step();
        out_accept = 2'b00;
        checks++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h3004 || out_pc1 !== 32'h3008 || out_pred0 !== 2'b01) begin
            errors++; $display("FAIL bpair_second: got v=%b pc=%h/%h pred0=%b want 11 00003004/00003008 01",
                               out_valid, out_pc0, out_pc1, out_pred0);
        end
        do_flush();
    endtask

    task automatic test_random();
        logic [1:0] ev;
        int         r;
        for (int c = 0; c < 600; c++) begin
            ev = exp_valid();
            checks++;
            if (out_valid !== ev) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, ev);
            end
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_ready());
            end
            if (mq.size() >= 1) begin
                checks++;
                if (out_pc0 !== mq[0].pc || out_instr0 !== mq[0].instr || out_pred0 !== mq[0].pred) begin
                    errors++; $display("FAIL rand_slot0[%0d]: got %h %h %b want %h %h %b", c,
                                       out_pc0, out_instr0, out_pred0, mq[0].pc, mq[0].instr, mq[0].pred);
                end
            end
            if (mq.size() >= 2) begin
                checks++;
                if (out_pc1 !== mq[1].pc || out_instr1 !== mq[1].instr || out_pred1 !== mq[1].pred) begin
                    errors++; $display("FAIL rand_slot1[%0d]: got %h %h %b want %h %h %b", c,
                                       out_pc1, out_instr1, out_pred1, mq[1].pc, mq[1].instr, mq[1].pred);
                end
            end
            in_valid     = ($urandom_range(0, 3) != 0);
            in_pc        = $urandom & 32'hFFFF_FFF8;
            in_instr     = {$urandom, $urandom};
            in_predecode = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            in_mask      = 2'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 40) == 0);
            r            = $urandom_range(0, 2);
            if (ev == 2'b11)      out_accept = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            else if (ev == 2'b01) out_accept = (r == 0) ? 2'b00 : 2'b01;
            else                  out_accept = 2'b00;
            step();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        resetn = 1'b1;
        test_reset();
        test_basic();
        test_half_group();
        test_full_wrap();
        test_back_to_back();
        test_flush_reset();
        test_branch_pair();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
